// File: rtl/sr_wport_arb.sv
// rtl/sr_wport_arb.sv - SR write-port arbiter: EX FIFO, trap holding register, read bypass
// Optional feature macro: SR_WARB_COALESCE_EN (merge pushes that hit the FIFO tail index).
module sr_wport_arb #(
  parameter int DATA_W     = 48,
  parameter int AIDX_W     = 2,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst_n,
  input  logic                     iw_ex_sr_we,
  input  logic [AIDX_W-1:0]        iw_ex_sr_addr,
  input  logic [DATA_W-1:0]        iw_ex_sr_data,
  input  logic                     iw_ex_aux_we,
  input  logic [AIDX_W-1:0]        iw_ex_aux_addr,
  input  logic [DATA_W-1:0]        iw_ex_aux_data,
  output logic                     ow_ex_ready,
  input  logic                     iw_trap_we,
  input  logic [AIDX_W-1:0]        iw_trap_addr,
  input  logic [DATA_W-1:0]        iw_trap_data,
  output logic                     ow_trap_ready,
  output logic                     ow_sr_we,
  output logic [AIDX_W-1:0]        ow_sr_addr,
  output logic [DATA_W-1:0]        ow_sr_data,
  input  logic [AIDX_W-1:0]        iw_rd_addr,
  output logic                     ow_rd_hit,
  output logic [DATA_W-1:0]        ow_rd_data,
  output logic [$clog2(DEPTH):0]   ow_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] READY_MAX = LW'(DEPTH - 2);

  logic [AIDX_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_trap_v;
  logic [AIDX_W-1:0] r_trap_addr;
  logic [DATA_W-1:0] r_trap_data;
  logic [SW-1:0]     r_starve;
  logic              r_sr_we;
  logic [AIDX_W-1:0] r_sr_addr;
  logic [DATA_W-1:0] r_sr_data;

  logic              w_fifo_ne, w_grant_trap, w_grant_fifo, w_trap_push;
  logic              w_wa0_en, w_wa1_en;
  logic [PW-1:0]     w_wa0_ptr, w_wa1_ptr;
  logic [LW-1:0]     w_push_n;

  assign w_fifo_ne     = (r_level != '0);
  assign ow_ex_ready   = iw_rst_n && (r_level <= READY_MAX);
  assign ow_trap_ready = iw_rst_n && !r_trap_v;
  assign w_grant_trap  = r_trap_v && (!w_fifo_ne || (r_starve < SW'(STARVE_MAX)));
  assign w_grant_fifo  = !w_grant_trap && w_fifo_ne;
  assign w_trap_push   = iw_trap_we && (!r_trap_v || w_grant_trap);

`ifdef SR_WARB_COALESCE_EN
  logic [PW-1:0] w_tail;
  logic          w_tail_ok;
  assign w_tail    = r_wptr - PW'(1);
  // The tail cannot be merged into when it is the head leaving this cycle.
  assign w_tail_ok = w_fifo_ne && !(w_grant_fifo && (r_level == LW'(1)));
`endif

  // sr is always placed before aux so aux is the younger entry.
  always_comb begin
    w_wa0_en  = 1'b0;
    w_wa1_en  = 1'b0;
    w_wa0_ptr = r_wptr;
    w_wa1_ptr = r_wptr;
    w_push_n  = '0;
    if (ow_ex_ready) begin
      if (iw_ex_sr_we) begin
        w_wa0_en = 1'b1;
`ifdef SR_WARB_COALESCE_EN
        if (w_tail_ok && (r_mem_addr[w_tail] == iw_ex_sr_addr)) begin
          w_wa0_ptr = w_tail;
        end else begin
          w_push_n = LW'(1);
        end
`else
        w_push_n = LW'(1);
`endif
      end
      if (iw_ex_aux_we) begin
        w_wa1_en = 1'b1;
`ifdef SR_WARB_COALESCE_EN
        if (iw_ex_sr_we && (iw_ex_aux_addr == iw_ex_sr_addr)) begin
          w_wa1_ptr = w_wa0_ptr;
        end else if (!iw_ex_sr_we && w_tail_ok && (r_mem_addr[w_tail] == iw_ex_aux_addr)) begin
          w_wa1_ptr = w_tail;
        end else begin
          w_wa1_ptr = r_wptr + w_push_n[PW-1:0];
          w_push_n  = w_push_n + LW'(1);
        end
`else
        w_wa1_ptr = r_wptr + w_push_n[PW-1:0];
        w_push_n  = w_push_n + LW'(1);
`endif
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_trap_v    <= 1'b0;
      r_trap_addr <= '0;
      r_trap_data <= '0;
      r_starve    <= '0;
      r_sr_we     <= 1'b0;
      r_sr_addr   <= '0;
      r_sr_data   <= '0;
    end else begin
      if (w_wa0_en) begin
        r_mem_addr[w_wa0_ptr] <= iw_ex_sr_addr;
        r_mem_data[w_wa0_ptr] <= iw_ex_sr_data;
      end
      if (w_wa1_en) begin
        r_mem_addr[w_wa1_ptr] <= iw_ex_aux_addr;
        r_mem_data[w_wa1_ptr] <= iw_ex_aux_data;
      end
      r_wptr  <= r_wptr + w_push_n[PW-1:0];
      r_level <= r_level + w_push_n - {{(LW-1){1'b0}}, w_grant_fifo};
      if (w_grant_fifo) r_rptr <= r_rptr + PW'(1);

      if (w_trap_push) begin
        r_trap_v    <= 1'b1;
        r_trap_addr <= iw_trap_addr;
        r_trap_data <= iw_trap_data;
      end else if (w_grant_trap) begin
        r_trap_v <= 1'b0;
      end

      if (w_grant_trap && w_fifo_ne) r_starve <= r_starve + SW'(1);
      else                           r_starve <= '0;

      r_sr_we <= w_grant_trap || w_grant_fifo;
      if (w_grant_trap) begin
        r_sr_addr <= r_trap_addr;
        r_sr_data <= r_trap_data;
      end else if (w_grant_fifo) begin
        r_sr_addr <= r_mem_addr[r_rptr];
        r_sr_data <= r_mem_data[r_rptr];
      end
    end
  end

  // Later matches override earlier ones: output reg, then FIFO oldest->youngest, then trap.
  always_comb begin
    ow_rd_hit  = 1'b0;
    ow_rd_data = '0;
    if (r_sr_we && (r_sr_addr == iw_rd_addr)) begin
      ow_rd_hit  = 1'b1;
      ow_rd_data = r_sr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((LW'(i) < r_level) && (r_mem_addr[r_rptr + PW'(i)] == iw_rd_addr)) begin
        ow_rd_hit  = 1'b1;
        ow_rd_data = r_mem_data[r_rptr + PW'(i)];
      end
    end
    if (r_trap_v && (r_trap_addr == iw_rd_addr)) begin
      ow_rd_hit  = 1'b1;
      ow_rd_data = r_trap_data;
    end
  end

  assign ow_sr_we   = r_sr_we;
  assign ow_sr_addr = r_sr_addr;
  assign ow_sr_data = r_sr_data;
  assign ow_level   = r_level;

endmodule

// File: tb/tb_sr_wport_arb.sv
// tb/tb_sr_wport_arb.sv - directed self-checking bench for sr_wport_arb (default DEPTH=4, STARVE_MAX=4)
module tb_sr_wport_arb;
  logic        iw_clk, iw_rst_n;
  logic        iw_ex_sr_we, iw_ex_aux_we, iw_trap_we;
  logic [1:0]  iw_ex_sr_addr, iw_ex_aux_addr, iw_trap_addr, iw_rd_addr;
  logic [47:0] iw_ex_sr_data, iw_ex_aux_data, iw_trap_data;
  logic        ow_ex_ready, ow_trap_ready, ow_sr_we, ow_rd_hit;
  logic [1:0]  ow_sr_addr;
  logic [47:0] ow_sr_data, ow_rd_data;
  logic [2:0]  ow_level;

  int n_checks = 0;
  int n_errors = 0;

  sr_wport_arb dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
    .iw_ex_sr_we(iw_ex_sr_we), .iw_ex_sr_addr(iw_ex_sr_addr), .iw_ex_sr_data(iw_ex_sr_data),
    .iw_ex_aux_we(iw_ex_aux_we), .iw_ex_aux_addr(iw_ex_aux_addr), .iw_ex_aux_data(iw_ex_aux_data),
    .ow_ex_ready(ow_ex_ready),
    .iw_trap_we(iw_trap_we), .iw_trap_addr(iw_trap_addr), .iw_trap_data(iw_trap_data),
    .ow_trap_ready(ow_trap_ready),
    .ow_sr_we(ow_sr_we), .ow_sr_addr(ow_sr_addr), .ow_sr_data(ow_sr_data),
    .iw_rd_addr(iw_rd_addr), .ow_rd_hit(ow_rd_hit), .ow_rd_data(ow_rd_data),
    .ow_level(ow_level)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic clr();
    iw_ex_sr_we = 0; iw_ex_aux_we = 0; iw_trap_we = 0;
    iw_ex_sr_addr = 0; iw_ex_aux_addr = 0; iw_trap_addr = 0; iw_rd_addr = 0;
    iw_ex_sr_data = 0; iw_ex_aux_data = 0; iw_trap_data = 0;
  endtask

  task automatic wr(input logic we, input logic [1:0] a, input logic [47:0] d);
    chk("sr_we", {47'd0, ow_sr_we}, {47'd0, we});
    if (we) begin
      chk("sr_addr", {46'd0, ow_sr_addr}, {46'd0, a});
      chk("sr_data", ow_sr_data, d);
    end
  endtask

  task automatic byp(input logic [1:0] a, input logic hit, input logic [47:0] d);
    iw_rd_addr = a;
    #1;
    chk("rd_hit", {47'd0, ow_rd_hit}, {47'd0, hit});
    chk("rd_data", ow_rd_data, d);
  endtask

  initial begin
    logic [1:0]  ea;
    logic [47:0] ed;
    clr();
    iw_rst_n = 0;
    tick(); tick();
    chk("rst_ex_ready", {47'd0, ow_ex_ready}, 48'd0);
    chk("rst_trap_ready", {47'd0, ow_trap_ready}, 48'd0);
    chk("rst_sr_addr", {46'd0, ow_sr_addr}, 48'd0);
    chk("rst_sr_data", ow_sr_data, 48'd0);
    chk("rst_level", {45'd0, ow_level}, 48'd0);
    wr(0, 0, 0);
    iw_rst_n = 1;
    tick();
    chk("ex_ready", {47'd0, ow_ex_ready}, 48'd1);
    chk("trap_ready", {47'd0, ow_trap_ready}, 48'd1);

    // single push, one-cycle latency
    iw_ex_sr_we = 1; iw_ex_sr_addr = 1; iw_ex_sr_data = 48'h000123;
    tick(); clr();
    chk("t1_level", {45'd0, ow_level}, 48'd1);
    wr(0, 0, 0);
    byp(1, 1, 48'h000123);
    tick();
    wr(1, 1, 48'h000123);
    chk("t1_level0", {45'd0, ow_level}, 48'd0);
    byp(1, 1, 48'h000123);
    tick();
    wr(0, 0, 0);
    byp(1, 0, 0);

    // same-cycle sr + aux to same index
    iw_ex_sr_we = 1; iw_ex_sr_addr = 2; iw_ex_sr_data = 48'hA;
    iw_ex_aux_we = 1; iw_ex_aux_addr = 2; iw_ex_aux_data = 48'h1;
    tick(); clr();
    byp(2, 1, 48'h1);
`ifdef SR_WARB_COALESCE_EN
    chk("t2_level", {45'd0, ow_level}, 48'd1);
    tick(); wr(1, 2, 48'h1);
    tick(); wr(0, 0, 0);
`else
    chk("t2_level", {45'd0, ow_level}, 48'd2);
    tick(); wr(1, 2, 48'hA);
    byp(2, 1, 48'h1);
    tick(); wr(1, 2, 48'h1);
    tick(); wr(0, 0, 0);
`endif

    // fill: a trap grant blocks the pop so the FIFO reaches 4
    iw_ex_sr_we = 1; iw_ex_sr_addr = 0; iw_ex_sr_data = 48'h10;
    iw_ex_aux_we = 1; iw_ex_aux_addr = 1; iw_ex_aux_data = 48'h11;
    iw_trap_we = 1; iw_trap_addr = 3; iw_trap_data = 48'h30;
    tick();
    iw_trap_we = 0;
    chk("t3_level2", {45'd0, ow_level}, 48'd2);
    chk("t3_ready2", {47'd0, ow_ex_ready}, 48'd1);
    chk("t3_trap_busy", {47'd0, ow_trap_ready}, 48'd0);
    iw_ex_sr_addr = 2; iw_ex_sr_data = 48'h12;
    iw_ex_aux_addr = 3; iw_ex_aux_data = 48'h13;
    tick();
    wr(1, 3, 48'h30);
    chk("t3_level4", {45'd0, ow_level}, 48'd4);
    chk("t3_full_ready", {47'd0, ow_ex_ready}, 48'd0);
    iw_ex_sr_addr = 0; iw_ex_sr_data = 48'h99;
    iw_ex_aux_addr = 1; iw_ex_aux_data = 48'h98;
    tick(); clr();
    wr(1, 0, 48'h10);
    chk("t3_level3", {45'd0, ow_level}, 48'd3);
    chk("t3_ready3", {47'd0, ow_ex_ready}, 48'd0);
    tick(); wr(1, 1, 48'h11); chk("t3_level_d2", {45'd0, ow_level}, 48'd2);
    tick(); wr(1, 2, 48'h12); chk("t3_level_d1", {45'd0, ow_level}, 48'd1);
    tick(); wr(1, 3, 48'h13); chk("t3_level_d0", {45'd0, ow_level}, 48'd0);
    tick(); wr(0, 0, 0);

    // starvation guard: 4 trap writes then 1 FIFO write
    iw_trap_we = 1; iw_trap_addr = 3; iw_trap_data = 48'h77;
    iw_ex_sr_we = 1; iw_ex_sr_addr = 0; iw_ex_sr_data = 48'hA0;
    iw_ex_aux_we = 1; iw_ex_aux_addr = 1; iw_ex_aux_data = 48'hA1;
    tick();
    chk("t4_level2", {45'd0, ow_level}, 48'd2);
    iw_ex_aux_we = 0; iw_ex_sr_addr = 2; iw_ex_sr_data = 48'hA2;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 0) begin
        iw_ex_sr_we = 0;
        chk("t4_level3", {45'd0, ow_level}, 48'd3);
      end
      if (k == 14) iw_trap_we = 0;
      if (k % 5 == 4) begin
        ea = 2'(k / 5);
        ed = 48'hA0 + 48'(k / 5);
      end else begin
        ea = 2'd3;
        ed = 48'h77;
      end
      wr(1, ea, ed);
    end
    chk("t4_level0", {45'd0, ow_level}, 48'd0);
    tick(); wr(1, 3, 48'h77);
    tick(); wr(0, 0, 0);

    // trap bypass over older FIFO entry, trap emitted first
    iw_ex_sr_we = 1; iw_ex_sr_addr = 3; iw_ex_sr_data = 48'h555;
    iw_trap_we = 1; iw_trap_addr = 3; iw_trap_data = 48'hFFFFFF;
    tick(); clr();
    byp(3, 1, 48'hFFFFFF);
    tick(); wr(1, 3, 48'hFFFFFF);
    byp(3, 1, 48'h555);
    tick(); wr(1, 3, 48'h555);
    tick(); wr(0, 0, 0);

    // reset drops pending writes
    iw_ex_sr_we = 1; iw_ex_sr_addr = 1; iw_ex_sr_data = 48'hB0;
    iw_ex_aux_we = 1; iw_ex_aux_addr = 2; iw_ex_aux_data = 48'hB1;
    tick();
    iw_ex_sr_addr = 1; iw_ex_sr_data = 48'hB2;
    iw_ex_aux_addr = 2; iw_ex_aux_data = 48'hB3;
    tick(); clr();
    chk("t6_level3", {45'd0, ow_level}, 48'd3);
    iw_rst_n = 0;
    tick();
    chk("t6_rst_ready", {47'd0, ow_ex_ready}, 48'd0);
    wr(0, 0, 0);
    tick();
    iw_rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      wr(0, 0, 0);
      chk("t6_level", {45'd0, ow_level}, 48'd0);
    end
    byp(1, 0, 0);
    byp(2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sr_wport_arb.md
Name: sr_wport_arb

Overview:
- Arbitrates and sequences all writes into the single special-register (SR) write port: EX-stage target-SR writes, EX-stage auxiliary PSTATE flag updates, and trap-unit writes.
- EX writes are queued in program order in one FIFO. Trap writes use a 1-entry holding register with priority and a starvation guard.
- A combinational read-bypass lets decode/EX see the youngest pending value for any SR index before it reaches the register file.

Parameters:
- DATA_W, 48, SR data width (matches address width).
- AIDX_W, 2, SR index width.
- DEPTH, 4, EX FIFO entries; power of two, >=2.
- STARVE_MAX, 4, consecutive trap grants allowed while the EX FIFO is non-empty.

Ports:
- iw_clk  in  1  clock
- iw_rst_n  in  1  reset, synchronous, active-low
- iw_ex_sr_we  in  1  EX target-SR write request
- iw_ex_sr_addr  in  AIDX_W  SR index
- iw_ex_sr_data  in  DATA_W  write data
- iw_ex_aux_we  in  1  EX flag (PSTATE) write request
- iw_ex_aux_addr  in  AIDX_W  SR index
- iw_ex_aux_data  in  DATA_W  write data
- ow_ex_ready  out  1  EX FIFO can accept two pushes this cycle
- iw_trap_we  in  1  trap-unit write request
- iw_trap_addr  in  AIDX_W  SR index
- iw_trap_data  in  DATA_W  write data
- ow_trap_ready  out  1  trap holding register empty
- ow_sr_we  out  1  SR file write enable (registered)
- ow_sr_addr  out  AIDX_W  SR file write index
- ow_sr_data  out  DATA_W  SR file write data
- iw_rd_addr  in  AIDX_W  bypass lookup index
- ow_rd_hit  out  1  pending write to iw_rd_addr exists
- ow_rd_data  out  DATA_W  youngest pending value for iw_rd_addr
- ow_level  out  $clog2(DEPTH)+1  EX FIFO occupancy

Behaviour:
- Reset (iw_rst_n=0 at posedge):
  - FIFO emptied, trap register cleared, starve counter cleared.
  - ow_sr_we=0, ow_sr_addr=0, ow_sr_data=0, ow_level=0.
  - ow_ex_ready=0 and ow_trap_ready=0 while reset is asserted.
  - Reset mid-operation drops all pending writes; none are emitted.
- ow_ex_ready = (DEPTH - level >= 2). ow_trap_ready = trap register empty. Both are combinational.
- EX push:
  - Accepted at posedge only when ow_ex_ready=1. Requests while not ready are ignored; the producer must stall and hold.
  - When both we bits are set in one cycle, the sr entry is enqueued before the aux entry. This holds even for the same index, so aux is the younger entry.
- Trap push: accepted at posedge when ow_trap_ready=1, or when the register is being granted that same cycle (back-to-back throughput).
- Grant, one per cycle, computed from state before this edge's pushes:
  - Trap register full and (FIFO empty or starve_cnt < STARVE_MAX): grant trap. starve_cnt increments if the FIFO is non-empty, else clears.
  - Otherwise, FIFO non-empty: grant FIFO head; starve_cnt clears.
  - Nothing pending: ow_sr_we=0 next cycle.
- Output register: the grant loads ow_sr_* at the posedge. Minimum latency is push at edge N, write visible during cycle N+1. ow_sr_we is high for exactly one cycle per write.
- Simultaneous push and pop on the FIFO is allowed; level = level + pushes - pop. Full with a pop still follows the ow_ex_ready rule; no bypass of full.
- Pointers wrap modulo DEPTH.
- Bypass (combinational), priority for a match on iw_rd_addr:
  1. Trap register.
  2. Youngest matching FIFO entry.
  3. Output register (ow_sr_we=1).
  - No match: ow_rd_hit=0, ow_rd_data=0.

Optional Feature:
- SR_WARB_COALESCE_EN defined:
  - A push to the same index as the current FIFO tail overwrites the tail's data instead of allocating, provided the tail is not the head being popped this cycle.
  - A same-cycle sr/aux pair to the same index collapses into one entry carrying the aux data.
  - ow_ex_ready is unchanged.
- Undefined: every push allocates an entry.

Test Plan:
- Reset, then push ex_sr (idx 1, 0x000123) -> ow_sr_we=1, addr 1, data 0x000123 exactly one cycle later; ow_level returns to 0.
- Same-cycle ex_sr (idx 2, 0xA) and ex_aux (idx 2, 0x1) -> writes 0xA then 0x1 on consecutive cycles; bypass on idx 2 returns 0x1 while pending.
  - With SR_WARB_COALESCE_EN: a single write of 0x1.
- Fill the FIFO with DEPTH=4 (two double pushes) -> ow_ex_ready=0 after the second push; a third push is ignored; ow_level=4 and drains 4,3,2,1,0.
- Trap requests held every cycle with the FIFO holding 3 entries -> 4 trap writes, then 1 FIFO write, repeating; all 3 FIFO writes complete.
- Trap push (idx 3, 0xFFFFFF) with an older FIFO entry for idx 3 -> ow_rd_data=0xFFFFFF; trap write is emitted first.
- Assert iw_rst_n=0 with 3 entries pending -> no further ow_sr_we; ow_level=0, ow_rd_hit=0 after release.
